pc_unit: RTL

//  Program-counter / next-PC unit of the single-cycle MIPS datapath. Drives pc_adress into the

---
 rtl/pc_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// pc_unit: program counter and next-PC selection for the single-cycle MIPS core.
// The core drives pc_adress into the instruction ROM and picks the next PC from four
// sources: sequential, branch, jump and jump-register. It tracks RUN/HALT/FAULT status
// and counts how many times the PC advances.
// Optional feature: define PC_ALIGN_CHECK_EN to make a misaligned jr target a fault.
// Without it, a jr target is forced to word alignment.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_RUN   | normal fetch; PC advances unless halt_req or stall is set
//   ST_HALT  | halt instruction seen; PC and count frozen until reset
//   ST_FAULT | illegal next PC (out of ROM range / misaligned jr); frozen until reset
module pc_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          MEM_SIZE   = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic [31:0] pc_adress,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        fault,
    output logic [31:0] inst_count
);

    // First byte address past the end of the instruction ROM.
    localparam logic [31:0] PC_LIMIT = 32'(MEM_SIZE * 4);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_count;
    logic [31:0] w_count_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_jr_target;
    logic        w_jr_misaligned;
    logic [31:0] w_target;

    assign w_pc_plus4 = r_pc + 32'd4;

`ifdef PC_ALIGN_CHECK_EN
    // A jr target must already be word aligned; low bits set are reported as a fault.
    assign w_jr_target     = reg_target;
    assign w_jr_misaligned = jump_reg && (reg_target[1:0] != 2'b00);
`else
    // The low address bits are dropped so a jr always lands on a word boundary.
    logic w_unused_align_bits;
    assign w_jr_target         = {reg_target[31:2], 2'b00};
    assign w_jr_misaligned     = 1'b0;
    assign w_unused_align_bits = ^reg_target[1:0];
`endif

    // Pick the redirect target by priority: jr, j/jal, taken branch, then sequential.
    always_comb begin
        w_target = w_pc_plus4;
        if (jump_reg) begin
            w_target = w_jr_target;
        end else if (jump) begin
            w_target = {w_pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            w_target = w_pc_plus4 + (branch_offset << 2);
        end
    end

    // Next state, next PC and next count. HALT and FAULT hold everything.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_count_nxt = r_count;
        case (r_state)
            ST_RUN: begin
                if (halt_req) begin
                    w_state_nxt = ST_HALT;
                end else if (!stall) begin
                    if (w_jr_misaligned || (w_target >= PC_LIMIT)) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_pc_nxt    = w_target;
                        w_count_nxt = r_count + 32'd1;
                    end
                end
            end
            ST_HALT:  w_state_nxt = ST_HALT;
            ST_FAULT: w_state_nxt = ST_FAULT;
            default:  w_state_nxt = ST_FAULT;
        endcase
    end

    // State, PC and advance counter registers. Reset overrides every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_ADDR;
            r_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign pc_adress  = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign inst_count = r_count;
    assign halted     = (r_state == ST_HALT);
    assign fault      = (r_state == ST_FAULT);

endmodule
